// File: rtl/seg_scan_mux.sv
// seg_scan_mux: registered N-channel seven-segment multiplexer with a manual mode and an auto-scan mode.
// In auto-scan each slot lasts DIVIDE cycles and starts with BLANK_CYCLES cycles of blanked output.
module seg_scan_mux #(
  parameter int WIDTH        = 7,
  parameter int CHANNELS     = 11,
  parameter int SEL_W        = 4,
  parameter int DIVIDE       = 50000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      enable,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      wrap
);

  localparam int PRE_W = $clog2(DIVIDE);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIVIDE - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] CH_LAST   = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_COUNT  = (SEL_W+1)'(CHANNELS);

  logic [SEL_W-1:0] ch_q, ch_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic             wrap_q, wrap_d;

  // Channel lookup; an index outside 0..CHANNELS-1 yields a blank code.
  function automatic logic [WIDTH-1:0] pick_ch(input logic [SEL_W-1:0] idx,
                                               input logic [CHANNELS*WIDTH-1:0] bus);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        res = bus[k*WIDTH +: WIDTH];
      end
    end
    return res;
  endfunction

  // Next-state logic for scan position, prescaler and output registers.
  always_comb begin
    ch_d        = ch_q;
    pre_d       = pre_q;
    mode_d      = mode_q;
    cur_ch_d    = cur_ch_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    if (enable) begin
      mode_d = mode;
      if (!mode) begin
        ch_d     = sel;
        pre_d    = '0;
        cur_ch_d = sel;
        if ({1'b0, sel} < CH_COUNT) begin
          out_d       = pick_ch(sel, in_bus);
          out_valid_d = 1'b1;
        end else begin
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      end else if (!mode_q) begin
        // Entering auto mode always restarts the scan from channel 0.
        ch_d     = '0;
        pre_d    = '0;
        cur_ch_d = '0;
      end else begin
        cur_ch_d = ch_q;
        if (pre_q < PRE_BLANK) begin
          out_d       = '0;
          out_valid_d = 1'b0;
        end else begin
          out_d       = pick_ch(ch_q, in_bus);
          out_valid_d = 1'b1;
        end
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (ch_q == CH_LAST) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d   = ch_q + SEL_W'(1);
            wrap_d = 1'b0;
          end
        end else begin
          pre_d  = pre_q + PRE_W'(1);
          wrap_d = 1'b0;
        end
      end
    end else begin
      out_d       = '0;
      out_valid_d = 1'b0;
      wrap_d      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      pre_q       <= '0;
      mode_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_ch_q    <= '0;
      wrap_q      <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      pre_q       <= pre_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_ch_q    <= cur_ch_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cur_ch    = cur_ch_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: the driver pushes the expected registered outputs for each
// clock edge, and a monitor pops and compares them just after that edge.
module tb_seg_scan_mux;
  localparam int W = 7;
  localparam int C = 11;
  localparam int S = 4;
  localparam int D = 4;
  localparam int B = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [C*W-1:0]   in_bus;
  logic [S-1:0]     sel;
  logic             mode;
  logic             enable;
  logic [W-1:0]     out;
  logic             out_valid;
  logic [S-1:0]     cur_ch;
  logic             wrap;

  typedef struct packed {
    logic [W-1:0] o;
    logic         v;
    logic [S-1:0] c;
    logic         w;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_ch   = 0;
  int   exp_pre  = 0;

  seg_scan_mux #(.WIDTH(W), .CHANNELS(C), .SEL_W(S), .DIVIDE(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .mode(mode), .enable(enable),
    .out(out), .out_valid(out_valid), .cur_ch(cur_ch), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(input logic en, input logic md, input logic [S-1:0] s,
                       input logic [W-1:0] o, input logic v, input logic [S-1:0] c, input logic w);
    exp_t e;
    enable = en;
    mode   = md;
    sel    = s;
    e.o = o; e.v = v; e.c = c; e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic en, input logic md, input logic [S-1:0] s,
                      input logic [W-1:0] o, input logic v, input logic [S-1:0] c, input logic w);
    @(negedge clk);
    apply(en, md, s, o, v, c, w);
  endtask

  task automatic set_bus_plain();
    for (int k = 0; k < C; k++) in_bus[k*W +: W] = W'(k + 1);
  endtask

  // Auto steady-state cycles: channel k shows k+1 after one blank cycle per slot.
  task automatic auto_steps(input int n);
    logic [W-1:0] o;
    logic         v;
    logic         w;
    for (int i = 0; i < n; i++) begin
      v = (exp_pre >= B);
      o = v ? W'(exp_ch + 1) : W'(0);
      w = (exp_pre == D - 1) && (exp_ch == C - 1);
      step(1'b1, 1'b1, S'(0), o, v, S'(exp_ch), w);
      if (exp_pre == D - 1) begin
        exp_pre = 0;
        exp_ch  = (exp_ch == C - 1) ? 0 : exp_ch + 1;
      end else begin
        exp_pre = exp_pre + 1;
      end
    end
  endtask

  // Monitor: compares each registered output set right after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out",       32'(out),       32'(e.o));
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("cur_ch",    32'(cur_ch),    32'(e.c));
        chk("wrap",      32'(wrap),      32'(e.w));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    for (int k = 0; k < C; k++) in_bus[k*W +: W] = W'($urandom);
    sel    = S'($urandom);
    mode   = 1'($urandom);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out",       32'(out),       32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_cur_ch",    32'(cur_ch),    32'(0));
    chk("rst_wrap",      32'(wrap),      32'(0));

    // Manual mode, including an out-of-range select and the top channel.
    set_bus_plain();
    in_bus[3*W +: W]  = 7'h4F;
    in_bus[10*W +: W] = 7'h7F;
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 4'd3, 7'h4F, 1'b1, 4'd3, 1'b0);
    step(1'b1, 1'b0, 4'd11, 7'h00, 1'b0, 4'd11, 1'b0);
    step(1'b1, 1'b0, 4'd10, 7'h7F, 1'b1, 4'd10, 1'b0);

    // Auto entry then one full scan plus part of the next.
    @(negedge clk);
    set_bus_plain();
    apply(1'b1, 1'b1, 4'd0, 7'h00, 1'b0, 4'd0, 1'b0);
    exp_ch = 0; exp_pre = 0;
    auto_steps(44);
    auto_steps(26);

    // Freeze at ch=6, pre=2.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'd0, 7'h00, 1'b0, 4'd6, 1'b0);
    auto_steps(8);

    // At ch=8: manual on channel 2 for three cycles, then back to auto.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd2, 7'h03, 1'b1, 4'd2, 1'b0);
    step(1'b1, 1'b1, 4'd0, 7'h00, 1'b0, 4'd0, 1'b0);
    exp_ch = 0; exp_pre = 0;
    auto_steps(22);

    // Async reset between edges while channel 5 is being shown.
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_out",       32'(out),       32'(0));
    chk("async_out_valid", 32'(out_valid), 32'(0));
    chk("async_cur_ch",    32'(cur_ch),    32'(0));
    chk("async_wrap",      32'(wrap),      32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 1'b1, 4'd0, 7'h00, 1'b0, 4'd0, 1'b0);
    exp_ch = 0; exp_pre = 0;
    auto_steps(8);

    @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
